// File: rtl/common_def_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Instruction width, NOP encoding and the slot FSM state type.
package common_def;

  localparam int INSTRUCTION_WIDTH = 12;

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR =
    12'b1011_0001_0001;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slot_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One elastic slot: main + skid entry under valid/ready.
// up_ready depends on the state register only, never on dn_ready.
module pipe_skid_slot
  import common_def::*;
#(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  slot_state_e  state;
  slot_state_e  state_nxt;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         push;
  logic         pop;
  logic         load_main;
  logic         load_skid;
  logic         skid_to_main;

  assign up_ready = (state != TWO);
  assign dn_valid = (state != EMPTY);
  assign dn_data  = main_q;
  assign push     = up_valid && up_ready;
  assign pop      = dn_valid && dn_ready;

  // State register; reset empties the slot at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and entry load controls; flush overrides all.
  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_nxt    = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
    if (flush) begin
      state_nxt    = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  // Payload entries; contents are don't-care while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= up_data;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= up_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: STAGES chained skid slots.
// Perf counters enabled by defining PIPE_PERF_CNT_EN.
module elastic_pipe_reg
  import common_def::*;
#(
  parameter int STAGES  = 1,
  parameter int CTRL_W  = 6,
  parameter int DATA_W  = 22,
  parameter int INSTR_W = INSTRUCTION_WIDTH,
  parameter logic [INSTR_W-1:0] NOP_VAL = NOP_INSTR,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int PW = CTRL_W + DATA_W + INSTR_W;

  logic [STAGES:0]         vld;
  logic [STAGES:0]         rdy;
  logic [STAGES:0][PW-1:0] dat;

  logic [CTRL_W-1:0]  last_ctrl;
  logic [DATA_W-1:0]  last_data;
  logic [INSTR_W-1:0] last_instr;

  assign vld[0]   = in_valid;
  assign dat[0]   = {in_ctrl, in_data, in_instr};
  assign in_ready = rdy[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    pipe_skid_slot #(
      .W(PW)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (vld[i]),
      .up_ready (rdy[i]),
      .up_data  (dat[i]),
      .dn_valid (vld[i+1]),
      .dn_ready (rdy[i+1]),
      .dn_data  (dat[i+1])
    );
  end

  assign rdy[STAGES] = out_ready;
  assign out_valid   = vld[STAGES];

  assign {last_ctrl, last_data, last_instr} = dat[STAGES];

  // Bubble mux: a bubble never carries side effects.
  always_comb begin
    out_ctrl  = '0;
    out_data  = '0;
    out_instr = NOP_VAL;
    if (out_valid) begin
      out_ctrl  = last_ctrl;
      out_data  = last_data;
      out_instr = last_instr;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Saturating counters; only rst clears them, flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (!out_valid && (bubble_q != '1)) begin
        bubble_q <= bubble_q + 1'b1;
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = {CNT_W{1'b0}};
  assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench for elastic_pipe_reg (STAGES=1 and 2).
// Counter checks follow PIPE_PERF_CNT_EN.
module tb_elastic_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [5:0]  in_ctrl;
  logic [21:0] in_data;
  logic [11:0] in_instr;
  logic        out_ready;

  logic        a_ir, a_ov;
  logic [5:0]  a_oc;
  logic [21:0] a_od;
  logic [11:0] a_oi;
  logic [3:0]  a_sc, a_bc;

  logic        b_ir, b_ov;
  logic [5:0]  b_oc;
  logic [21:0] b_od;
  logic [11:0] b_oi;
  logic [3:0]  b_sc, b_bc;

  int total = 0;
  int bad   = 0;

  logic [11:0] olog[$];

  always #5 clk = ~clk;

  elastic_pipe_reg #(.STAGES(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_ir),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .in_instr(in_instr),
    .out_valid(a_ov), .out_ready(out_ready),
    .out_ctrl(a_oc), .out_data(a_od),
    .out_instr(a_oi),
    .stall_cnt(a_sc), .bubble_cnt(a_bc)
  );

  elastic_pipe_reg #(.STAGES(2), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_ir),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .in_instr(in_instr),
    .out_valid(b_ov), .out_ready(out_ready),
    .out_ctrl(b_oc), .out_data(b_od),
    .out_instr(b_oi),
    .stall_cnt(b_sc), .bubble_cnt(b_bc)
  );

  // Log u1 output handshakes that will complete at the next edge.
  always @(negedge clk) begin
    if (!rst && !flush && a_ov && out_ready) begin
      olog.push_back(a_oi);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_ctrl  = 6'h3F;
    in_data  = 22'h3FFFFF;
    in_instr = 12'hFFF;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    idle_in();
    step();
    flush = 1'b0;
  endtask

  task automatic beat(input logic [5:0] c,
                      input logic [21:0] d,
                      input logic [11:0] i);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    in_instr = i;
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [5:0]  c;
    logic [21:0] d;
    logic [11:0] ins;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [5:0]  e_c;
    logic [21:0] e_d;
    logic [11:0] e_i;
  } vec_t;

  vec_t tv[14];

  localparam logic [11:0] NOP = 12'hB11;

  logic [3:0] sat_exp;
  logic [3:0] cnt_exp3;

  initial begin
`ifdef PIPE_PERF_CNT_EN
    sat_exp  = 4'd15;
    cnt_exp3 = 4'd3;
`else
    sat_exp  = 4'd0;
    cnt_exp3 = 4'd0;
`endif

    tv[0]  = '{0,1,6'h05,22'h11,12'h101,1,
               1,1,6'h05,22'h11,12'h101};
    tv[1]  = '{0,1,6'h0A,22'h22,12'h102,1,
               1,1,6'h0A,22'h22,12'h102};
    tv[2]  = '{0,0,6'h3F,22'h3FFFFF,12'hFFF,1,
               1,0,6'h00,22'h0,NOP};
    tv[3]  = '{0,0,6'h3F,22'h3FFFFF,12'hFFF,0,
               1,0,6'h00,22'h0,NOP};
    tv[4]  = '{0,1,6'h11,22'h33,12'h103,0,
               1,1,6'h11,22'h33,12'h103};
    tv[5]  = '{0,1,6'h12,22'h44,12'h104,0,
               0,1,6'h11,22'h33,12'h103};
    tv[6]  = '{0,1,6'h13,22'h55,12'h105,0,
               0,1,6'h11,22'h33,12'h103};
    tv[7]  = '{0,1,6'h13,22'h55,12'h105,1,
               1,1,6'h12,22'h44,12'h104};
    tv[8]  = '{0,1,6'h13,22'h55,12'h105,1,
               1,1,6'h13,22'h55,12'h105};
    tv[9]  = '{0,1,6'h14,22'h66,12'h106,0,
               0,1,6'h13,22'h55,12'h105};
    tv[10] = '{1,1,6'h15,22'h77,12'h7FF,1,
               1,0,6'h00,22'h0,NOP};
    tv[11] = '{0,0,6'h15,22'h77,12'h7FF,1,
               1,0,6'h00,22'h0,NOP};
    tv[12] = '{0,1,6'h00,22'h3FFFFF,12'h000,0,
               1,1,6'h00,22'h3FFFFF,12'h000};
    tv[13] = '{1,0,6'h00,22'h0,12'h000,0,
               1,0,6'h00,22'h0,NOP};

    // 1: reset state
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle_in();
    #1;
    chk("rst_ov2", {31'd0, b_ov}, 0);
    chk("rst_oi2", {20'd0, b_oi}, {20'd0, NOP});
    chk("rst_oc2", {26'd0, b_oc}, 0);
    chk("rst_ir2", {31'd0, b_ir}, 1);
    chk("rst_sc1", {28'd0, a_sc}, 0);
    chk("rst_bc1", {28'd0, a_bc}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    chk("bub3", {28'd0, a_bc}, {28'd0, cnt_exp3});

    // Table: STAGES=1 single-cycle vectors
    for (int k = 0; k < 14; k++) begin
      flush     = tv[k].fl;
      in_valid  = tv[k].iv;
      in_ctrl   = tv[k].c;
      in_data   = tv[k].d;
      in_instr  = tv[k].ins;
      out_ready = tv[k].ordy;
      step();
      chk($sformatf("v%0d_ir", k),
          {31'd0, a_ir}, {31'd0, tv[k].e_ir});
      chk($sformatf("v%0d_ov", k),
          {31'd0, a_ov}, {31'd0, tv[k].e_ov});
      chk($sformatf("v%0d_oc", k),
          {26'd0, a_oc}, {26'd0, tv[k].e_c});
      chk($sformatf("v%0d_od", k),
          {10'd0, a_od}, {10'd0, tv[k].e_d});
      chk($sformatf("v%0d_oi", k),
          {20'd0, a_oi}, {20'd0, tv[k].e_i});
    end
    flush = 1'b0;

    // 2: streaming through STAGES=2
    out_ready = 1'b1;
    do_flush();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        beat(6'(i + 1), 22'(i * 3),
             12'(12'h101 + i));
      end else begin
        idle_in();
      end
      step();
      chk($sformatf("s%0d_ir", i), {31'd0, b_ir}, 1);
      if (i >= 1 && i <= 8) begin
        chk($sformatf("s%0d_ov", i), {31'd0, b_ov}, 1);
        chk($sformatf("s%0d_oi", i),
            {20'd0, b_oi}, 32'(12'h100 + i));
        chk($sformatf("s%0d_oc", i),
            {26'd0, b_oc}, 32'(i));
      end else begin
        chk($sformatf("s%0d_ov", i), {31'd0, b_ov}, 0);
      end
    end

    // 3: backpressure on STAGES=1
    do_flush();
    out_ready = 1'b0;
    olog.delete();
    beat(6'h01, 22'h1, 12'hA01);
    step();
    chk("bp_ir1", {31'd0, a_ir}, 1);
    beat(6'h02, 22'h2, 12'hA02);
    step();
    chk("bp_ir2", {31'd0, a_ir}, 0);
    chk("bp_oi2", {20'd0, a_oi}, 32'hA01);
    beat(6'h03, 22'h3, 12'hA03);
    step();
    chk("bp_hold", {20'd0, a_oi}, 32'hA01);
    chk("bp_ir3", {31'd0, a_ir}, 0);
    out_ready = 1'b1;
    step();
    chk("bp_oi4", {20'd0, a_oi}, 32'hA02);
    step();
    idle_in();
    step();
    step();
    chk("bp_n", olog.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < olog.size()) begin
        chk($sformatf("bp_o%0d", i),
            {20'd0, olog[i]}, 32'(12'hA01 + i));
      end
    end

    // 4: flush collides with an offered beat
    olog.delete();
    out_ready = 1'b0;
    beat(6'h21, 22'h10, 12'h301);
    step();
    beat(6'h22, 22'h20, 12'h302);
    step();
    chk("fc_full", {31'd0, a_ir}, 0);
    flush     = 1'b1;
    out_ready = 1'b1;
    beat(6'h3F, 22'h3FFFFF, 12'h7FF);
    step();
    flush = 1'b0;
    chk("fc_ov", {31'd0, a_ov}, 0);
    chk("fc_oi", {20'd0, a_oi}, {20'd0, NOP});
    chk("fc_ov2", {31'd0, b_ov}, 0);
    chk("fc_ir", {31'd0, a_ir}, 1);
    idle_in();
    repeat (3) begin
      step();
      chk("fc_quiet", {31'd0, a_ov}, 0);
    end
    chk("fc_log", olog.size(), 0);

    // 5: bubble gating of side-effect bits
    in_valid = 1'b0;
    in_ctrl  = 6'h3F;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bg%0d_1", i), {26'd0, a_oc}, 0);
      chk($sformatf("bg%0d_2", i), {26'd0, b_oc}, 0);
    end

    // 6: stall counter saturation, untouched by flush
    out_ready = 1'b0;
    beat(6'h2A, 22'h155, 12'h5A5);
    step();
    idle_in();
    repeat (20) step();
    chk("st_oi", {20'd0, a_oi}, 32'h5A5);
    chk("st_oc", {26'd0, a_oc}, 32'h2A);
    chk("st_sat", {28'd0, a_sc}, {28'd0, sat_exp});
    chk("bb_sat", {28'd0, a_bc}, {28'd0, sat_exp});
    do_flush();
    chk("st_flush", {28'd0, a_sc}, {28'd0, sat_exp});

    // Reset mid-transfer drops everything at once
    beat(6'h01, 22'h1, 12'h111);
    step();
    beat(6'h02, 22'h2, 12'h222);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("mr_ov", {31'd0, a_ov}, 0);
    chk("mr_ir", {31'd0, a_ir}, 1);
    chk("mr_oi", {20'd0, a_oi}, {20'd0, NOP});
    chk("mr_sc", {28'd0, a_sc}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_in();
    step();
    chk("mr_ov2", {31'd0, a_ov}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end

endmodule
